// File: rtl/sr_pulse_sequencer.sv
// sr_pulse_sequencer
//   Turns two raw, bouncing pushbuttons into clean, mutually exclusive S/R
//   pulses for a downstream SR latch. It also tracks the state that latch
//   should hold.
//   Each button goes through a 2-flop synchronizer and then a debouncer.
//   The rising edge of the debounced level posts a one-deep pending request.
//   A small FSM serves the requests one at a time:
//   IDLE -> pulse (PULSE_CYCLES) -> GAP (1 cycle) -> IDLE.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronized cycles before a level is accepted (1..255)
//   PULSE_CYCLES     width of each S/R pulse in clocks (1..15)
//   PRIORITY_RESET   1: reset request wins a conflict, 0: set request wins
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   set_btn    raw set pushbutton (async, active-high)
//   reset_btn  raw reset pushbutton (async, active-high)
//   S, R       registered set/reset pulses, never high together
//   q_model    registered copy of the expected latch Q
//   busy       FSM is not IDLE
//   conflict   set and reset both pending while IDLE (one cycle)

// Synchronizer + debouncer for one button. Produces a one-cycle pulse on the
// clock after the debounced level rises.
module sr_pulse_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       s1_q, s2_q;
    logic       db_q, db_d;
    logic       db_prev_q;
    logic [7:0] cnt_q, cnt_d;

    // Count consecutive cycles in which the synchronized input disagrees
    // with the accepted level. Flip on the DEBOUNCE_CYCLES-th cycle. Any
    // cycle in which they agree clears the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST) db_d = s2_q;
            else                   cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            s1_q      <= btn;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
        end
    end

    assign rise = db_q & ~db_prev_q;
endmodule

module sr_pulse_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int PRIORITY_RESET  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic reset_btn,
    output logic S,
    output logic R,
    output logic q_model,
    output logic busy,
    output logic conflict
);
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SET_PULSE   = 2'd1,
        RESET_PULSE = 2'd2,
        GAP         = 2'd3
    } state_e;

    localparam logic [3:0] PCNT_LAST = 4'(PULSE_CYCLES - 1);

    logic       set_rise, reset_rise;
    state_e     state_q, state_d;
    logic [3:0] pcnt_q, pcnt_d;
    logic       pend_set_q, pend_set_d;
    logic       pend_reset_q, pend_reset_d;
    logic       s_q, s_d, r_q, r_d, qm_q, qm_d;

    sr_pulse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk(clk), .rst(rst), .btn(set_btn), .rise(set_rise)
    );
    sr_pulse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
        .clk(clk), .rst(rst), .btn(reset_btn), .rise(reset_rise)
    );

    // A request is held until its pulse state is entered. A rise that lands
    // in the same cycle as the service is a fresh press, so it re-arms the
    // flag. Extra rises while a request is pending merge into it.
    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        pend_set_d   = pend_set_q | set_rise;
        pend_reset_d = pend_reset_q | reset_rise;
        conflict     = 1'b0;
        unique case (state_q)
            IDLE: begin
                pcnt_d = '0;
                if (pend_set_q && pend_reset_q) begin
                    conflict = 1'b1;
                    if (PRIORITY_RESET != 0) begin
                        state_d      = RESET_PULSE;
                        pend_reset_d = reset_rise;
                    end else begin
                        state_d    = SET_PULSE;
                        pend_set_d = set_rise;
                    end
                end else if (pend_set_q) begin
                    state_d    = SET_PULSE;
                    pend_set_d = set_rise;
                end else if (pend_reset_q) begin
                    state_d      = RESET_PULSE;
                    pend_reset_d = reset_rise;
                end
            end
            SET_PULSE, RESET_PULSE: begin
                if (pcnt_q == PCNT_LAST) begin
                    state_d = GAP;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // S/R are registered copies of the next state, so they line up
        // exactly with the pulse states and cannot overlap.
        s_d  = (state_d == SET_PULSE);
        r_d  = (state_d == RESET_PULSE);
        qm_d = s_q ? 1'b1 : (r_q ? 1'b0 : qm_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pcnt_q       <= '0;
            pend_set_q   <= 1'b0;
            pend_reset_q <= 1'b0;
            s_q          <= 1'b0;
            r_q          <= 1'b0;
            qm_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            pend_set_q   <= pend_set_d;
            pend_reset_q <= pend_reset_d;
            s_q          <= s_d;
            r_q          <= r_d;
            qm_q         <= qm_d;
        end
    end

    assign S       = s_q;
    assign R       = r_q;
    assign q_model = qm_q;
    assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// Bench for sr_pulse_sequencer (default parameters).
// A cycle-level behavioural model predicts every output and is compared on
// each falling edge. Directed scenarios pin absolute timings with literals.
module tb_sr_pulse_sequencer;
    localparam int DB = 4;
    localparam int PW = 2;
    localparam int PRIO_RST = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_btn = 1'b0;
    logic reset_btn = 1'b0;
    logic S, R, q_model, busy, conflict;

    int total = 0;
    int bad = 0;

    sr_pulse_sequencer #(
        .DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(PW), .PRIORITY_RESET(PRIO_RST)
    ) dut (
        .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
        .S(S), .R(R), .q_model(q_model), .busy(busy), .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 = set button, 1 = reset button.
    // m_left counts the cycles left in the current service:
    // PW pulse cycles followed by one gap cycle.
    logic [1:0] m_s1 = '0, m_s2 = '0, m_prev = '0, m_db = '0, m_dbp = '0, m_pend = '0;
    int         m_run [2] = '{0, 0};
    int         m_left = 0;
    int         m_kind = 0;
    logic       m_q = 1'b0;
    logic       mS, mR, mbusy, mconf;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_prev = '0; m_db = '0; m_dbp = '0; m_pend = '0;
            m_run[0] = 0; m_run[1] = 0; m_left = 0; m_kind = 0; m_q = 1'b0;
        end else begin
            logic [1:0] rise;
            int pick;
            rise = m_db & ~m_dbp;
            // latch state follows whichever pulse was on in the last cycle
            if (m_left > 1) m_q = (m_kind == 0);
            if (m_left > 0) m_left--;
            else if (m_pend != 2'b00) begin
                if (m_pend == 2'b11) pick = PRIO_RST ? 1 : 0;
                else                 pick = m_pend[1] ? 1 : 0;
                m_kind = pick;
                m_left = PW + 1;
                m_pend[pick] = 1'b0;
            end
            m_pend = m_pend | rise;
            m_dbp = m_db;
            // debounced level: synchronized value held for DB samples in a row
            for (int b = 0; b < 2; b++) begin
                if (m_s2[b] == m_prev[b]) m_run[b]++;
                else                      m_run[b] = 1;
                m_prev[b] = m_s2[b];
                if (m_s2[b] != m_db[b] && m_run[b] >= DB) m_db[b] = m_s2[b];
            end
            m_s2 = m_s1;
            m_s1 = {reset_btn, set_btn};
        end
        mS    = (m_left > 1) && (m_kind == 0);
        mR    = (m_left > 1) && (m_kind == 1);
        mbusy = (m_left > 0);
        mconf = (m_left == 0) && (m_pend == 2'b11);
    end

    // ---------------- compare + invariant monitor ----------------
    int s_run = 0, r_run = 0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            s_run = 0; r_run = 0;
        end else begin
            chk("model_S", S, mS);
            chk("model_R", R, mR);
            chk("model_q", q_model, m_q);
            chk("model_busy", busy, mbusy);
            chk("model_conflict", conflict, mconf);
            chk("s_r_exclusive", S & R, 0);
            if (S) s_run++;
            else if (s_run > 0) begin chk("s_width", s_run, PW); s_run = 0; end
            if (R) r_run++;
            else if (r_run > 0) begin chk("r_width", r_run, PW); r_run = 0; end
        end
    end

    // Count pulses (rising edges) and high cycles over n falling edges.
    task automatic watch(input int n, output int sp, output int rp, output int shi);
        logic ps, pr;
        ps = S; pr = R; sp = 0; rp = 0; shi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (S && !ps) sp++;
            if (R && !pr) rp++;
            if (S) shi++;
            ps = S; pr = R;
        end
    endtask

    initial begin
        int first_s, first_r, first_c, s_hi, r_hi, b_hi, c_hi, sp, rp, shi;
        bit found;

        // reset state while rst held
        repeat (2) @(negedge clk);
        chk("rst_S", S, 0); chk("rst_R", R, 0); chk("rst_q", q_model, 0);
        chk("rst_busy", busy, 0); chk("rst_conflict", conflict, 0);
        @(negedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: clean set press; first sampled at edge 0, S from edge 7
        set_btn = 1'b1;
        first_s = -1; s_hi = 0; b_hi = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (S) begin s_hi++; if (first_s < 0) first_s = k; end
            if (busy) b_hi++;
            if (k == 7) chk("t1_q_before", q_model, 0);
            if (k == 8) chk("t1_q_after", q_model, 1);
        end
        chk("t1_first_S", first_s, 7);
        chk("t1_S_cycles", s_hi, 2);
        chk("t1_busy_cycles", b_hi, 3);
        set_btn = 1'b0;
        repeat (20) @(negedge clk);

        // 2: both pressed together, reset priority
        set_btn = 1'b1; reset_btn = 1'b1;
        first_s = -1; first_r = -1; first_c = -1; s_hi = 0; r_hi = 0; c_hi = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (S) begin s_hi++; if (first_s < 0) first_s = k; end
            if (R) begin r_hi++; if (first_r < 0) first_r = k; end
            if (conflict) begin c_hi++; if (first_c < 0) first_c = k; end
            if (k == 10) chk("t2_q_after_R", q_model, 0);
            if (k == 12) chk("t2_q_after_S", q_model, 1);
        end
        chk("t2_conflict_at", first_c, 6);
        chk("t2_conflict_cycles", c_hi, 1);
        chk("t2_first_R", first_r, 7);
        chk("t2_R_cycles", r_hi, 2);
        chk("t2_first_S", first_s, 11);
        chk("t2_S_cycles", s_hi, 2);
        set_btn = 1'b0; reset_btn = 1'b0;
        repeat (20) @(negedge clk);

        // 3: bounce every 2 cycles for 20 cycles, then stable high
        s_hi = 0;
        for (int k = 0; k < 20; k++) begin
            set_btn = ((k / 2) % 2 == 0);
            @(negedge clk);
            if (S) s_hi++;
        end
        chk("t3_no_S_in_bounce", s_hi, 0);
        set_btn = 1'b1;
        watch(30, sp, rp, shi);
        chk("t3_one_S_after", sp, 1);
        chk("t3_no_R", rp, 0);
        set_btn = 1'b0;
        repeat (20) @(negedge clk);

        // 4: rst during second S cycle
        set_btn = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (S) found = 1;
        end
        chk("t4_S_seen", found, 1);
        @(negedge clk);
        chk("t4_S_second_cycle", S, 1);
        #1 rst = 1'b1;
        #1;
        chk("t4_S_forced_low", S, 0); chk("t4_R_low", R, 0);
        chk("t4_q_low", q_model, 0); chk("t4_busy_low", busy, 0);
        chk("t4_conflict_low", conflict, 0);
        set_btn = 1'b0;
        @(negedge clk); #1 rst = 1'b0;
        watch(30, sp, rp, shi);
        chk("t4_no_S_after", sp, 0);
        chk("t4_no_R_after", rp, 0);

        // 5: button held across rst release -> exactly one pulse
        set_btn = 1'b1;
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        watch(40, sp, rp, shi);
        chk("t5_one_S", sp, 1);
        set_btn = 1'b0;
        repeat (20) @(negedge clk);

        // 6: reset_btn held 100 cycles
        reset_btn = 1'b1;
        watch(100, sp, rp, shi);
        chk("t6_one_R", rp, 1);
        chk("t6_no_S", sp, 0);
        chk("t6_busy_idle", busy, 0);
        reset_btn = 1'b0;
        repeat (20) @(negedge clk);

        // 7: random button activity, model + invariants check every cycle
        begin
            int hs, hr;
            hs = 0; hr = 0;
            for (int k = 0; k < 10000; k++) begin
                if (hs == 0) begin set_btn = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 12); end
                if (hr == 0) begin reset_btn = 1'($urandom_range(0, 1)); hr = $urandom_range(1, 12); end
                hs--; hr--;
                @(negedge clk);
            end
        end
        set_btn = 1'b0; reset_btn = 1'b0;
        repeat (30) @(negedge clk);
        chk("end_busy_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_pulse_sequencer.md
SR_PULSE_SEQUENCER -- requirements
Module: sr_pulse_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles required before a button level is accepted (range 1..255).
REQ-002 Parameter PULSE_CYCLES, default 2: width in clock cycles of each emitted S or R pulse (range 1..15).
REQ-003 Parameter PRIORITY_RESET, default 1: 1 = reset request served first on conflict, 0 = set request first.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 set_btn  input  1  raw asynchronous set pushbutton, active-high, may bounce.
REQ-007 reset_btn  input  1  raw asynchronous reset pushbutton, active-high, may bounce.
REQ-008 S  output  1  registered set pulse driving the downstream SR latch.
REQ-009 R  output  1  registered reset pulse driving the downstream SR latch.
REQ-010 q_model  output  1  registered expected latch Q (Qa) state.
REQ-011 busy  output  1  high whenever FSM is not IDLE.
REQ-012 conflict  output  1  one-cycle pulse when set and reset requests are pending together.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Per button: debounced level db_x SHALL change only after synchronized input differs from db_x for DEBOUNCE_CYCLES consecutive cycles; any equal cycle clears that counter.
REQ-015 Rising edge of db_set SHALL set pend_set; rising edge of db_reset SHALL set pend_reset; falling edges ignored.
REQ-016 Pending flags SHALL hold until serviced; a new rising edge while already pending is absorbed (no queueing beyond one).
REQ-017 Pending flag SHALL clear in the cycle its pulse state is entered.
REQ-018 FSM states: IDLE, SET_PULSE, RESET_PULSE, GAP.
REQ-019 IDLE: pend_set only -> SET_PULSE; pend_reset only -> RESET_PULSE; both -> state per PRIORITY_RESET, other flag stays pending, conflict=1 for that cycle.
REQ-020 SET_PULSE: S=1, R=0 for exactly PULSE_CYCLES cycles, then GAP; RESET_PULSE symmetric with R=1, S=0.
REQ-021 GAP: S=R=0 for exactly 1 cycle, then IDLE (pending requests evaluated there).
REQ-022 S and R SHALL never be 1 in the same cycle, under any input sequence.
REQ-023 Latency: db_x rises at edge N -> pending visible at N+1 -> pulse output high from edge N+2 when FSM is IDLE at N+1.
REQ-024 q_model SHALL become 1 on the edge after the first S=1 cycle and 0 on the edge after the first R=1 cycle; unchanged otherwise.
REQ-025 Pulse in progress SHALL complete its full width; requests arriving mid-pulse wait for IDLE.
REQ-026 Button held high continuously SHALL yield exactly one pulse.

Reset
REQ-027 While rst=1, regardless of clk: S=0, R=0, q_model=0, busy=0, conflict=0, FSM=IDLE, pending flags, db levels, synchronizers and counters = 0.
REQ-028 rst asserted mid-pulse SHALL force S/R low immediately; after release no pulse resumes unless a new debounced rising edge occurs.
REQ-029 Button held high across rst release SHALL produce one pulse after synchronizer+debounce delay.

Verification
REQ-030 Clean set_btn press (defaults): S=1 for 2 cycles starting 2+4+2 cycles after first sampled high, q_model=1 next cycle, busy high 3 cycles.
REQ-031 set_btn bouncing every 2 cycles for 20 cycles, then stable high: no pulse during bounce, exactly one S pulse after.
REQ-032 Both buttons debounced same cycle, PRIORITY_RESET=1: conflict=1 one cycle, R pulse 2 cycles, 1 gap cycle, S pulse 2 cycles; q_model 0 then 1.
REQ-033 Random buttons 10k cycles: S&R never 1 together; each pulse exactly PULSE_CYCLES; q_model matches NOR SR latch Qa fed by S/R.
REQ-034 rst pulsed during second cycle of S pulse: S=0 within same timestep, all outputs 0, no pulse after release with buttons low.
REQ-035 reset_btn held high 100 cycles: exactly one R pulse, busy returns 0.
